// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath.
// Holds operand/frame/epoch geometry, the epoch count type and the
// framer FSM state encoding. The downstream deserializer and up-counter
// import this package so every stage agrees on epoch timing.
package sc_pkg;

  localparam int DATA_W    = 9;       // operand width
  localparam int FRAME_W   = 10;      // DATA_W data bits + 1 guard bit
  localparam int EPOCH_LEN = 131073;  // cycles per epoch (2^17 + 1)
  localparam int EPOCH_W   = 18;

  typedef logic [EPOCH_W-1:0] epoch_t;

  typedef enum logic [1:0] {
    GAP   = 2'd0,
    SHIFT = 2'd1,
    GUARD = 2'd2
  } frame_state_t;

endpackage

// File: rtl/sc_epoch_counter.sv
// Free-running epoch position counter, 0 .. EPOCH_LEN-1.
// Ports:
//   clk, rst_n      clock, asynchronous active-high reset
//   epoch_cnt       current epoch position
//   epoch_start     high while epoch_cnt == 0
//   epoch_last      high while epoch_cnt == EPOCH_LEN-1
module sc_epoch_counter
  import sc_pkg::*;
#(
  parameter int EPOCH_LEN = sc_pkg::EPOCH_LEN
) (
  input  logic   clk,
  input  logic   rst_n,
  output epoch_t epoch_cnt,
  output logic   epoch_start,
  output logic   epoch_last
);

  localparam epoch_t LAST = epoch_t'(EPOCH_LEN - 1);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)           epoch_cnt <= '0;
    else if (epoch_last) epoch_cnt <= '0;
    else                 epoch_cnt <= epoch_cnt + epoch_t'(1);
  end

  assign epoch_start = (epoch_cnt == '0);
  assign epoch_last  = (epoch_cnt == LAST);

endmodule

// File: rtl/sc_operand_framer.sv
// Operand framer: accepts bipolar operand pairs over valid/ready, holds
// one pending pair, and serializes one pair per epoch as a 10-bit frame
// (9 data bits LSB-first, then a zero guard bit). With no new pair the
// last issued pair is re-sent every epoch.
// Ports:
//   clk, rst_n      clock, asynchronous active-high reset
//   op_valid/ready  operand handshake; ready = pending buffer empty
//   op_a, op_b      operands (9'h100 = 0.0)
//   ser_a, ser_b    registered serial frames
//   epoch_cnt       epoch position, epoch_start high at count 0
//   frame_active    high while data or guard bits are on ser_*
module sc_operand_framer
  import sc_pkg::*;
#(
  parameter int DATA_W    = sc_pkg::DATA_W,
  parameter int FRAME_W   = sc_pkg::FRAME_W,
  parameter int EPOCH_LEN = sc_pkg::EPOCH_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              ser_a,
  output logic              ser_b,
  output epoch_t            epoch_cnt,
  output logic              epoch_start,
  output logic              frame_active
);

  // Index of the last data bit; reaching it hands over to the guard bit.
  localparam logic [3:0] LAST_DATA = 4'(FRAME_W - 1);

  logic epoch_last;

  sc_epoch_counter #(.EPOCH_LEN(EPOCH_LEN)) u_epoch (
    .clk         (clk),
    .rst_n       (rst_n),
    .epoch_cnt   (epoch_cnt),
    .epoch_start (epoch_start),
    .epoch_last  (epoch_last)
  );

  frame_state_t state, state_nxt;

  logic [DATA_W-1:0] pend_a, pend_b, cur_a, cur_b, sh_a, sh_b;
  logic [DATA_W-1:0] src_a, src_b;
  logic              pend_full;
  logic [3:0]        idx;
  logic              launch_q;
  logic              launch;
  logic              accept;

  // Registered copy of epoch_last, so it is high exactly during count 0.
  // Reset value 1 matches the counter restarting at 0: the first edge
  // after release launches a frame.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) launch_q <= 1'b1;
    else       launch_q <= epoch_last;
  end

  assign launch   = launch_q && (state == GAP);
  assign op_ready = !pend_full;
  assign accept   = op_valid && !pend_full;

  // A full pending buffer wins at launch; otherwise repeat the last pair.
  assign src_a = pend_full ? pend_a : cur_a;
  assign src_b = pend_full ? pend_b : cur_b;

  // FSM: state register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= GAP;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      GAP:     if (launch) state_nxt = SHIFT;
      SHIFT:   if (idx == LAST_DATA) state_nxt = GUARD;
      GUARD:   state_nxt = GAP;
      default: state_nxt = GAP;
    endcase
  end

  // FSM: outputs
  always_comb begin
    frame_active = (state == SHIFT) || (state == GUARD);
  end

  // Datapath. Bit 0 is loaded straight into ser_* at the launch edge so it
  // is on the wire during count 1; the shifter then supplies bits 1..8.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pend_a    <= '0;
      pend_b    <= '0;
      pend_full <= 1'b0;
      cur_a     <= '0;
      cur_b     <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      idx       <= '0;
      ser_a     <= 1'b0;
      ser_b     <= 1'b0;
    end else begin
      if (launch) begin
        if (pend_full) begin
          cur_a     <= pend_a;
          cur_b     <= pend_b;
          pend_full <= 1'b0;
        end
        ser_a <= src_a[0];
        ser_b <= src_b[0];
        sh_a  <= src_a >> 1;
        sh_b  <= src_b >> 1;
        idx   <= 4'd1;
      end else if (state == SHIFT && idx != LAST_DATA) begin
        ser_a <= sh_a[0];
        ser_b <= sh_b[0];
        sh_a  <= sh_a >> 1;
        sh_b  <= sh_b >> 1;
        idx   <= idx + 4'd1;
      end else begin
        ser_a <= 1'b0;
        ser_b <= 1'b0;
      end
      // Accept needs an empty buffer, so it never collides with the
      // launch that drains a full one.
      if (accept) begin
        pend_a    <= op_a;
        pend_b    <= op_b;
        pend_full <= 1'b1;
      end
    end
  end

endmodule
